// File: rtl/task_dispatcher.sv
`default_nettype none
// ============================================================================
// task_dispatcher -- launches one task at a time on a selected engine, watches
// it with a watchdog, and muxes that engine's SRAM command bundles. Rev 1.0
// ============================================================================
module task_dispatcher #(
   parameter int                NUM_SRAM    = 4,
   parameter int                NUM_ENGINES = 2,
   parameter int                ADDR_W      = 24,
   parameter logic [ADDR_W-1:0] MAX_ADDR    = ADDR_W'('h1FFFF),
   parameter int                TIMEOUT     = 24'hFF_FFFF
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [8+3*ADDR_W-1:0]                  rpi_inst,
   input  logic                                   execute_task,
   output logic                                   inst_valid,
   output logic                                   idle,
   output logic                                   task_done,
   output logic [1:0]                             status,
   output logic [3*ADDR_W-1:0]                    op_addr,
   output logic [NUM_ENGINES-1:0]                 eng_execute,
   output logic [NUM_ENGINES-1:0]                 eng_abort,
   input  logic [NUM_ENGINES-1:0]                 eng_job_done,
   input  logic [NUM_ENGINES*NUM_SRAM*8-1:0]      eng_sram_inst,
   input  logic [NUM_ENGINES*NUM_SRAM*ADDR_W-1:0] eng_sram_address,
   input  logic [NUM_ENGINES*NUM_SRAM-1:0]        eng_sram_write_in,
   input  logic [NUM_ENGINES*NUM_SRAM*ADDR_W-1:0] eng_sram_byte_length,
   output logic [NUM_SRAM*8-1:0]                  sram_inst,
   output logic [NUM_SRAM*ADDR_W-1:0]             sram_address,
   output logic [NUM_SRAM-1:0]                    sram_write_in,
   output logic [NUM_SRAM*ADDR_W-1:0]             sram_byte_length
);

   localparam int               SEL_W     = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
   localparam int               CNT_W     = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [1:0]       ST_OK      = 2'b01;
   localparam logic [1:0]       ST_TIMEOUT = 2'b10;
   localparam logic [1:0]       ST_REJECT  = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      RUN    = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t                  state_q;
   logic                    idle_q;
   logic                    task_done_q;
   logic [1:0]              status_q;
   logic [3*ADDR_W-1:0]     op_addr_q;
   logic [SEL_W-1:0]        sel_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [NUM_ENGINES-1:0]  eng_execute_q;

   logic [7:0]              opcode_w;
   logic [7:0]              sel_full_w;
   logic [SEL_W-1:0]        sel_new_w;
   logic                    job_sel_w;
   logic                    timeout_w;
   logic                    mux_en_w;

   assign opcode_w   = rpi_inst[8+3*ADDR_W-1 -: 8];
   assign sel_full_w = 8'hFF - opcode_w;
   assign sel_new_w  = sel_full_w[SEL_W-1:0];

   always_comb begin
      inst_valid = (opcode_w != 8'd0) && (int'(opcode_w) >= 256 - NUM_ENGINES);
      for (int i = 0; i < 3; i++) begin
         if (rpi_inst[i*ADDR_W +: ADDR_W] > MAX_ADDR) inst_valid = 1'b0;
      end
   end

   // Only the selected engine's completion counts; done wins a tie with the watchdog.
   assign job_sel_w = eng_job_done[sel_q];
   assign timeout_w = (state_q == RUN) && (cnt_q == CNT_LAST) && !job_sel_w;
   assign eng_abort = timeout_w ? (NUM_ENGINES'(1) << sel_q) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         idle_q        <= 1'b1;
         task_done_q   <= 1'b0;
         status_q      <= 2'b00;
         op_addr_q     <= '0;
         sel_q         <= '0;
         cnt_q         <= '0;
         eng_execute_q <= '0;
      end else begin
         eng_execute_q <= '0;
         task_done_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (execute_task) begin
                  if (inst_valid) begin
                     state_q       <= START;
                     idle_q        <= 1'b0;
                     op_addr_q     <= rpi_inst[3*ADDR_W-1:0];
                     sel_q         <= sel_new_w;
                     eng_execute_q <= NUM_ENGINES'(1) << sel_new_w;
                  end else begin
                     status_q <= ST_REJECT;
                  end
               end
            end
            START: begin
               cnt_q   <= '0;
               state_q <= RUN;
            end
            RUN: begin
               cnt_q <= cnt_q + 1'b1;
               if (job_sel_w) begin
                  state_q     <= FINISH;
                  task_done_q <= 1'b1;
                  status_q    <= ST_OK;
               end else if (cnt_q == CNT_LAST) begin
                  state_q     <= FINISH;
                  task_done_q <= 1'b1;
                  status_q    <= ST_TIMEOUT;
               end
            end
            FINISH: begin
               state_q <= IDLE;
               idle_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign idle        = idle_q;
   assign task_done   = task_done_q;
   assign status      = status_q;
   assign op_addr     = op_addr_q;
   assign eng_execute = eng_execute_q;

   // SRAM ports belong to the running engine only while a task is in flight.
   assign mux_en_w = (state_q == START) || (state_q == RUN);

   always_comb begin
      sram_inst        = '0;
      sram_address     = '0;
      sram_write_in    = '0;
      sram_byte_length = '0;
      if (mux_en_w) begin
         sram_inst        = eng_sram_inst[int'(sel_q)*NUM_SRAM*8 +: NUM_SRAM*8];
         sram_address     = eng_sram_address[int'(sel_q)*NUM_SRAM*ADDR_W +: NUM_SRAM*ADDR_W];
         sram_write_in    = eng_sram_write_in[int'(sel_q)*NUM_SRAM +: NUM_SRAM];
         sram_byte_length = eng_sram_byte_length[int'(sel_q)*NUM_SRAM*ADDR_W +: NUM_SRAM*ADDR_W];
      end
   end

endmodule
`default_nettype wire

// File: doc/task_dispatcher.md
TASK_DISPATCHER -- requirements
Module: task_dispatcher

Parameters
REQ-001 NUM_SRAM, 4, number of SRAM channels muxed.
REQ-002 NUM_ENGINES, 2, task engines; opcode 255-k selects engine k, for k in 0..NUM_ENGINES-1.
REQ-003 ADDR_W, 24, SRAM address and byte-length width.
REQ-004 MAX_ADDR, 'h1FFFF, highest legal operand address.
REQ-005 TIMEOUT, 2^24-1, RUN-state cycle limit before abort; minimum 2.

Interface
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 rpi_inst  in  8+3*ADDR_W  [top 8] opcode; then op_addr0, op_addr1, op_addr2 (MSB to LSB).
REQ-009 execute_task  in  1  request to launch rpi_inst.
REQ-010 inst_valid  out  1  combinational: opcode in the legal range and all three operands <= MAX_ADDR.
REQ-011 idle  out  1  registered; dispatcher in IDLE.
REQ-012 task_done  out  1  one-cycle pulse at task end, on success or timeout.
REQ-013 status  out  2  00 none, 01 ok, 10 timeout, 11 rejected; holds until the next event.
REQ-014 op_addr  out  3*ADDR_W  operands latched at accept; broadcast to engines.
REQ-015 eng_execute  out  NUM_ENGINES  one-hot, one-cycle start pulse.
REQ-016 eng_abort  out  NUM_ENGINES  one-hot, one-cycle abort pulse on timeout.
REQ-017 eng_job_done  in  NUM_ENGINES  per-engine completion level or pulse.
REQ-018 eng_sram_inst / eng_sram_address / eng_sram_write_in / eng_sram_byte_length  in  NUM_ENGINES x NUM_SRAM x {8, ADDR_W, 1, ADDR_W}  per-engine SRAM command bundles, flattened engine-major.
REQ-019 sram_inst / sram_address / sram_write_in / sram_byte_length  out  NUM_SRAM x {8, ADDR_W, 1, ADDR_W}  muxed SRAM commands.

Function
REQ-020 FSM states: IDLE, START, RUN, FINISH.
REQ-021 Accept condition: IDLE and execute_task=1 and inst_valid=1.
- Next cycle: state START, idle=0.
- Latch op_addr and sel = 255-opcode.
REQ-022 Reject condition: IDLE and execute_task=1 and inst_valid=0.
- status<=11; no state change; no engine pulse.
REQ-023 Opcode 0 and all opcodes below 256-NUM_ENGINES are invalid.
REQ-024 START lasts one cycle.
- eng_execute[sel]=1; all other eng_execute bits 0.
- Watchdog counter cleared; next state RUN.
REQ-025 RUN, per cycle: counter increments.
- eng_job_done[sel]=1 -> FINISH with status ok.
- Else counter==TIMEOUT-1 -> eng_abort[sel]=1 for that cycle, then FINISH with status timeout.
REQ-026 eng_job_done bits of unselected engines are ignored in all states.
REQ-027 In the same RUN cycle, job_done takes priority over timeout.
REQ-028 FINISH lasts one cycle.
- task_done=1; status updated; next state IDLE.
- idle returns to 1 on the following cycle.
REQ-029 SRAM mux:
- START, RUN: sram_* equal the selected engine's bundle.
- IDLE, FINISH: sram_inst=0, sram_address=0, sram_write_in=0, sram_byte_length=0.
REQ-030 execute_task outside IDLE is ignored; it does not change status.
REQ-031 Accept-to-eng_execute latency is 1 cycle; job_done-to-task_done latency is 1 cycle.

Reset
REQ-032 reset=1 at a clock edge forces IDLE from any state.
- idle=1, status=00, op_addr=0, counter=0.
- eng_execute=0, eng_abort=0, task_done=0.
REQ-033 reset takes priority over all other inputs.
- No abort or done pulse is issued for a task killed by reset.

Verification
REQ-034 Launch: opcode 255, operands 0x10/0x20/0x30, execute_task one cycle.
- eng_execute=01 one cycle later.
- op_addr latched as given.
- sram_* follow engine 0.
REQ-035 Completion: engine 1 (opcode 254) asserts job_done 5 cycles after start.
- task_done pulses 1 cycle later; status=01; idle=1 on the next cycle.
REQ-036 Rejection: opcode 253 with NUM_ENGINES=2, or operand 0x20000.
- inst_valid=0; status=11; idle stays 1; no eng_execute.
REQ-037 Timeout: TIMEOUT=8, no job_done.
- eng_abort[sel] in the 8th RUN cycle, then task_done with status=10.
REQ-038 Collision and reset:
- job_done in the same cycle as the timeout -> status=01, no abort.
- reset in RUN -> IDLE next cycle, sram_* zeroed, no task_done.
